axi_sram_slave: RTL and testbench

- AXI3-style responder (slave) backed by an on-chip word-addressed memory array.
- Closes the loop for the CPU's AXI master bridge in simulation/SoC top: accepts AR/AW/W, returns R/B.
- Independent read and write engines share one memory: 1 write port, 1 read port. Supports FIXED/INCR/WRAP bursts up to 16 beats.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_burst_addr.sv | 39 +++
 rtl/axi_sram_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the state types used by the SRAM responder.
// The CPU master bridge uses the same burst and response encodings.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_BURST_LEN = 16;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address generator for FIXED/INCR/WRAP bursts.
// Also flags bursts this responder cannot honour, which are answered with SLVERR.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        illegal
);

  logic [31:0] incr;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic        wrap_len_ok;

  always_comb begin
    incr        = 32'd1 << size;
    incr_addr   = addr + incr;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Window is (len+1) beats, a power of two whenever wrap_len_ok holds.
    wrap_mask   = ((32'(len) + 32'd1) << size) - 32'd1;

    illegal = (size > 3'd2) ||
              (32'(len) > (MAX_BURST_LEN - 1)) ||
              (burst == 2'b11) ||
              ((burst == BURST_WRAP) && !wrap_len_ok);

    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_len_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                           : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder over a word-addressed on-chip memory with independent
// read and write engines sharing one write port and one read port.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int DEPTH  = 1 << (ADDR_W - 2);
  localparam int WORD_W = ADDR_W - 2;

  // Holds the address channels closed for the first cycle out of reset.
  logic live_reg;

  // ---------------- read engine ----------------
  rd_state_t         rd_state_reg, rd_state_next;
  logic [31:0]       rd_addr_reg;
  logic [7:0]        rd_len_reg, rd_beat_reg;
  logic [2:0]        rd_size_reg;
  logic [1:0]        rd_burst_reg, rresp_reg;
  logic [ID_W-1:0]   rid_reg;
  logic              rd_idle, rd_last, ar_fire, r_fire, rd_en;
  logic [31:0]       rd_gen_addr, rd_next_addr;
  logic [2:0]        rd_gen_size;
  logic [7:0]        rd_gen_len;
  logic [1:0]        rd_gen_burst;
  logic              rd_illegal;
  logic [WORD_W-1:0] rd_idx;

  // ---------------- write engine ----------------
  wr_state_t         wr_state_reg, wr_state_next;
  logic [31:0]       wr_addr_reg;
  logic [7:0]        wr_len_reg, wr_beat_reg;
  logic [2:0]        wr_size_reg;
  logic [1:0]        wr_burst_reg;
  logic [ID_W-1:0]   bid_reg;
  logic              werr_reg;
  logic              wr_idle, wr_last, aw_fire, w_fire;
  logic [31:0]       wr_gen_addr, wr_next_addr;
  logic [2:0]        wr_gen_size;
  logic [7:0]        wr_gen_len;
  logic [1:0]        wr_gen_burst;
  logic              wr_illegal;
  logic [WORD_W-1:0] wr_idx;

  always_ff @(posedge aclk) begin
    if (!aresetn) live_reg <= 1'b0;
    else          live_reg <= 1'b1;
  end

  // While idle the generators see the incoming request so its legality is known at the handshake.
  assign rd_idle      = (rd_state_reg == R_IDLE);
  assign rd_gen_addr  = rd_idle ? araddr  : rd_addr_reg;
  assign rd_gen_size  = rd_idle ? arsize  : rd_size_reg;
  assign rd_gen_len   = rd_idle ? arlen   : rd_len_reg;
  assign rd_gen_burst = rd_idle ? arburst : rd_burst_reg;

  axi_burst_addr u_rd_addr (
    .addr      (rd_gen_addr),
    .size      (rd_gen_size),
    .len       (rd_gen_len),
    .burst     (rd_gen_burst),
    .next_addr (rd_next_addr),
    .illegal   (rd_illegal)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    ar_fire       = 1'b0;
    r_fire        = 1'b0;
    rd_last       = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        ar_fire = live_reg && arvalid;
        if (ar_fire) rd_state_next = R_DATA;
      end
      R_DATA: begin
        rd_last = (rd_beat_reg == rd_len_reg);
        r_fire  = rready;
        if (r_fire && rd_last) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
    rd_en  = ar_fire || (r_fire && !rd_last);
    rd_idx = ar_fire ? araddr[ADDR_W-1:2] : rd_next_addr[ADDR_W-1:2];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_reg <= R_IDLE;
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_beat_reg  <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= '0;
      rresp_reg    <= RESP_OKAY;
      rid_reg      <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (ar_fire) begin
        rd_addr_reg  <= araddr;
        rd_len_reg   <= arlen;
        rd_size_reg  <= arsize;
        rd_burst_reg <= arburst;
        rd_beat_reg  <= '0;
        rid_reg      <= arid;
        rresp_reg    <= rd_illegal ? RESP_SLVERR : RESP_OKAY;
      end else if (r_fire && !rd_last) begin
        rd_addr_reg <= rd_next_addr;
        rd_beat_reg <= rd_beat_reg + 8'd1;
      end
    end
  end

  assign arready = live_reg && rd_idle;
  assign rvalid  = (rd_state_reg == R_DATA);
  assign rlast   = rvalid && (rd_beat_reg == rd_len_reg);
  assign rid     = rid_reg;
  assign rresp   = rresp_reg;

  assign wr_idle      = (wr_state_reg == W_IDLE);
  assign wr_gen_addr  = wr_idle ? awaddr  : wr_addr_reg;
  assign wr_gen_size  = wr_idle ? awsize  : wr_size_reg;
  assign wr_gen_len   = wr_idle ? awlen   : wr_len_reg;
  assign wr_gen_burst = wr_idle ? awburst : wr_burst_reg;
  assign wr_idx       = wr_addr_reg[ADDR_W-1:2];

  axi_burst_addr u_wr_addr (
    .addr      (wr_gen_addr),
    .size      (wr_gen_size),
    .len       (wr_gen_len),
    .burst     (wr_gen_burst),
    .next_addr (wr_next_addr),
    .illegal   (wr_illegal)
  );

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    wr_last       = (wr_beat_reg == wr_len_reg);
    case (wr_state_reg)
      W_IDLE: begin
        aw_fire = live_reg && awvalid;
        if (aw_fire) wr_state_next = W_DATA;
      end
      W_DATA: begin
        w_fire = wvalid;
        if (w_fire && wr_last) wr_state_next = W_RESP;
      end
      W_RESP: begin
        if (bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_reg <= W_IDLE;
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_beat_reg  <= '0;
      wr_size_reg  <= '0;
      wr_burst_reg <= '0;
      bid_reg      <= '0;
      werr_reg     <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      if (aw_fire) begin
        wr_addr_reg  <= awaddr;
        wr_len_reg   <= awlen;
        wr_size_reg  <= awsize;
        wr_burst_reg <= awburst;
        wr_beat_reg  <= '0;
        bid_reg      <= awid;
        werr_reg     <= wr_illegal;
      end else if (w_fire) begin
        wr_addr_reg <= wr_next_addr;
        wr_beat_reg <= wr_beat_reg + 8'd1;
        if ((wid != bid_reg) || (wlast != wr_last)) werr_reg <= 1'b1;
      end
    end
  end

  assign awready = live_reg && wr_idle;
  assign wready  = (wr_state_reg == W_DATA);
  assign bvalid  = (wr_state_reg == W_RESP);
  assign bid     = bid_reg;
  assign bresp   = (bvalid && werr_reg) ? RESP_SLVERR : RESP_OKAY;

  // One byte-wide RAM per lane; a same-cycle read sees the pre-write contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge aclk) begin
      if (w_fire && wstrb[gi]) mem_lane[wr_idx] <= wdata[gi*8 +: 8];
    end

    always_ff @(posedge aclk) begin
      if (!aresetn)   rd_byte_reg <= '0;
      else if (rd_en) rd_byte_reg <= mem_lane[rd_idx];
    end

    assign rdata[gi*8 +: 8] = rd_byte_reg;
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected R/B responses
// computed from a byte-level memory model; a monitor pops and compares.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int ID_W     = 4;
  localparam int MAX_WAIT = 300;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, rresp, awburst, bresp;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
    logic [ID_W-1:0] id;
    bit              chk_data;
  } r_exp_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] wd_arr [256];
  logic [3:0]  ws_arr [256];
  int          tests = 0;
  int          fails = 0;
  int          r_seen = 0;
  int          ready_mode = 0;  // 0 always, 1 random, 2 toggle, 3 rready low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out after %0d cycles, want handshake", name, MAX_WAIT);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_illegal(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
    bit wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (size > 2) || (len > 15) || (burst == 2'b11) || (burst == BURST_WRAP && !wrap_ok);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int n);
    longint unsigned incr = longint'(1) << size;
    longint unsigned window, base, s;
    s = longint'(start);
    if (burst == BURST_FIXED) return start;
    if (burst == BURST_WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      window = (longint'(len) + 1) * incr;
      base   = s - (s % window);
      return 32'(base + ((s - base + longint'(n) * incr) % window));
    end
    return 32'(s + longint'(n) * incr);
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[ADDR_W-1:2]);
  endfunction

  // ---------------- ready drivers ----------------
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        1:       begin rready = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1)); end
        2:       begin rready = ~rready; bready = 1'b1; end
        3:       begin rready = 1'b0; bready = 1'b1; end
        default: begin rready = 1'b1; bready = 1'b1; end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          held = 0;
    logic [31:0] held_data;
    logic        held_last;
    r_exp_t      re;
    b_exp_t      be;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        held = 0;
      end else begin
        if (held && rvalid) begin
          check("r_stall_data", rdata, held_data);
          check("r_stall_last", 32'(rlast), 32'(held_last));
        end
        if (rvalid && rready) begin
          held = 0;
          if (r_q.size() == 0) begin
            check("r_unexpected_beat", 32'(rvalid), 32'd0);
          end else begin
            re = r_q.pop_front();
            if (re.chk_data) check("rdata", rdata, re.data);
            check("rresp", 32'(rresp), 32'(re.resp));
            check("rlast", 32'(rlast), 32'(re.last));
            check("rid", 32'(rid), 32'(re.id));
            r_seen++;
            if (re.last) $display("[TB] R burst done id=%0d resp=%0d", rid, rresp);
          end
        end else if (rvalid) begin
          held      = 1;
          held_data = rdata;
          held_last = rlast;
        end else begin
          held = 0;
        end
        if (bvalid && bready) begin
          if (b_q.size() == 0) begin
            check("b_unexpected", 32'(bvalid), 32'd0);
          end else begin
            be = b_q.pop_front();
            check("bid", 32'(bid), 32'(be.id));
            check("bresp", 32'(bresp), 32'(be.resp));
            $display("[TB] B id=%0d resp=%0d", bid, bresp);
          end
        end
      end
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic issue_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit chk,
                          output bit ok);
    int     n = 0;
    r_exp_t e;
    ok = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < MAX_WAIT) begin @(negedge aclk); n++; end
    if (!arready) begin
      timeout_fail("ar_handshake");
      arvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      int k = widx(beat_addr(addr, size, len, burst, i));
      e.chk_data = chk && ref_mem.exists(k);
      e.data     = e.chk_data ? ref_mem[k] : 32'd0;
      e.resp     = model_illegal(size, len, burst) ? RESP_SLVERR : RESP_OKAY;
      e.last     = (i == int'(len));
      e.id       = id;
      r_q.push_back(e);
    end
    check("r_first_latency", 32'(rvalid), 32'd1);
    ok = 1;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit chk);
    int n = 0;
    bit ok;
    issue_ar(id, addr, len, size, burst, chk, ok);
    if (!ok) return;
    while (r_q.size() != 0 && n < MAX_WAIT) begin @(negedge aclk); n++; end
    if (r_q.size() != 0) begin
      timeout_fail("r_drain");
      r_q.delete();
    end
    @(posedge aclk);
    #1;
    check("r_idle_after_burst", 32'(rvalid), 32'd0);
  endtask

  // bad[0]: wlast high on every beat; bad[1]: wrong wid on beat 0
  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] bad);
    int     n = 0;
    bit     err;
    b_exp_t e;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < MAX_WAIT) begin @(negedge aclk); n++; end
    if (!awready) begin
      timeout_fail("aw_handshake");
      awvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    err = model_illegal(size, len, burst) || (bad != 2'b00 && (bad[1] || len != 0));
    e.id   = id;
    e.resp = err ? RESP_SLVERR : RESP_OKAY;
    b_q.push_back(e);
    for (int i = 0; i <= int'(len); i++) begin
      int          k = widx(beat_addr(addr, size, len, burst, i));
      logic [31:0] w = ref_mem.exists(k) ? ref_mem[k] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (ws_arr[i][b]) w[b*8 +: 8] = wd_arr[i][b*8 +: 8];
      ref_mem[k] = w;
      wid    = (bad[1] && i == 0) ? id ^ 4'd1 : id;
      wdata  = wd_arr[i];
      wstrb  = ws_arr[i];
      wlast  = bad[0] ? 1'b1 : (i == int'(len));
      wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!wready && n < MAX_WAIT) begin @(negedge aclk); n++; end
      if (!wready) begin
        timeout_fail("w_handshake");
        wvalid = 1'b0;
        b_q.delete();
        return;
      end
      @(posedge aclk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    n = 0;
    while (b_q.size() != 0 && n < MAX_WAIT) begin @(negedge aclk); n++; end
    if (b_q.size() != 0) begin
      timeout_fail("b_response");
      b_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_random(input int beats, input bit full_strobe);
    for (int i = 0; i < beats; i++) begin
      wd_arr[i] = $urandom;
      ws_arr[i] = full_strobe ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_arready", 32'(arready), 32'd1);

    // Fill words 0x000..0x1FF so every later read has a known value.
    for (int b = 0; b < 8; b++) begin
      fill_random(16, 1);
      do_write(4'(b), 32'(b * 64), 8'd15, 3'd2, BURST_INCR, 2'b00);
    end

    wd_arr[0] = 32'hDEADBEEF; ws_arr[0] = 4'hF;
    do_write(4'd3, 32'h10, 8'd0, 3'd2, BURST_INCR, 2'b00);
    do_read(4'd5, 32'h10, 8'd0, 3'd2, BURST_INCR, 1);

    wd_arr[0] = 32'h11223344; ws_arr[0] = 4'hF;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, BURST_INCR, 2'b00);
    wd_arr[0] = 32'hAABBCCDD; ws_arr[0] = 4'b0101;
    do_write(4'd2, 32'h20, 8'd0, 3'd2, BURST_INCR, 2'b00);
    do_read(4'd2, 32'h20, 8'd0, 3'd2, BURST_INCR, 1);

    ready_mode = 2;
    do_read(4'd1, 32'h40, 8'd3, 3'd2, BURST_INCR, 1);
    ready_mode = 0;
    do_read(4'd2, 32'h38, 8'd3, 3'd2, BURST_WRAP, 1);
    do_read(4'd9, 32'h64, 8'd2, 3'd2, BURST_FIXED, 1);

    fill_random(2, 1);
    do_write(4'd4, 32'h80, 8'd1, 3'd2, BURST_INCR, 2'b01);
    do_read(4'd6, 32'h90, 8'd1, 3'd3, BURST_INCR, 0);
    fill_random(1, 1);
    do_write(4'd7, 32'h84, 8'd0, 3'd2, 2'b11, 2'b00);
    fill_random(2, 1);
    do_write(4'd8, 32'hA0, 8'd1, 3'd2, BURST_INCR, 2'b10);
    do_read(4'd8, 32'h80, 8'd7, 3'd2, BURST_INCR, 1);

    // Upper address bits alias onto the same words.
    fill_random(1, 1);
    do_write(4'd10, 32'h0001_0010, 8'd0, 3'd2, BURST_INCR, 2'b00);
    do_read(4'd11, 32'h10, 8'd0, 3'd2, BURST_INCR, 1);

    // Reset in the middle of an 8-beat read.
    n = r_seen;
    issue_ar(4'd12, 32'h100, 8'd7, 3'd2, BURST_INCR, 1, ok);
    if (ok) begin
      int c = 0;
      while (r_seen < n + 2 && c < MAX_WAIT) begin @(posedge aclk); #1; c++; end
      if (r_seen < n + 2) timeout_fail("rst_mid_beats");
    end
    ready_mode = 3;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_arready", 32'(arready), 32'd0);
    check("midrst_rlast", 32'(rlast), 32'd0);
    r_q.delete();
    aresetn = 1'b1;
    ready_mode = 0;
    @(posedge aclk);
    #1;
    check("midrst_release_arready", 32'(arready), 32'd1);
    do_read(4'd13, 32'h100, 8'd3, 3'd2, BURST_INCR, 1);
    do_read(4'd14, 32'h20, 8'd0, 3'd2, BURST_INCR, 1);

    // Random mix against the model, with random ready back-pressure.
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      logic [ID_W-1:0] id    = 4'($urandom);
      logic [2:0]      size  = 3'($urandom_range(0, 2));
      logic [1:0]      burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      logic [7:0]      len;
      logic [31:0]     addr  = 32'($urandom_range(0, 32'h1C0));
      if (burst == BURST_WRAP) len = 8'((2 << $urandom_range(0, 3)) - 1);
      else                     len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(int'(len) + 1, 0);
        do_write(id, addr, len, size, burst, 2'($urandom_range(0, 5) == 0 ? $urandom_range(1, 3) : 0));
      end else begin
        do_read(id, addr, len, size, burst, 1);
      end
    end
    ready_mode = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("final_r_queue_empty", 32'(r_q.size()), 32'd0);
    check("final_b_queue_empty", 32'(b_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
